uart_cmd_rx: RTL



---
 rtl/uart_cmd_rx_if.sv | 28 ++
 rtl/uart_cmd_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx_if.sv
// Command-side bus of the UART command receiver: assembled command, ready/clear
// handshake and the three single-cycle error strobes.
interface uart_cmd_rx_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        frm_err;
  logic        ovr_err;
  logic        to_err;

  modport master (
    output cmd,
    output cmd_rdy,
    output frm_err,
    output ovr_err,
    output to_err,
    input  clr_cmd_rdy
  );

  modport slave (
    input  cmd,
    input  cmd_rdy,
    input  frm_err,
    input  ovr_err,
    input  to_err,
    output clr_cmd_rdy
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// Host command receiver: 8N1 UART deserializer feeding a two-byte command
// assembler with inter-byte timeout, overrun and framing-error filtering.
module uart_cmd_rx #(
  parameter int BAUD_DIV = 868,
  parameter int TIMEOUT  = 1_000_000,
  parameter int BW       = 10,
  parameter int TW       = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RX,
  uart_cmd_rx_if.master cmd_if
);

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_START = 2'd1,
    B_DATA  = 2'd2,
    B_STOP  = 2'd3
  } bit_state_t;

  typedef enum logic [1:0] {
    A_WAIT_HI = 2'd0,
    A_WAIT_LO = 2'd1,
    A_HOLD    = 2'd2
  } asm_state_t;

  localparam logic [BW-1:0] HALF_LOAD = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_LOAD = BW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT);

  logic          rx_meta_r;
  logic          rxs_r;
  logic          rx_prev_r;

  bit_state_t    bit_state_r,  bit_state_nxt_s;
  logic [BW-1:0] baud_cnt_r,   baud_cnt_nxt_s;
  logic [2:0]    bit_cnt_r,    bit_cnt_nxt_s;
  logic [7:0]    shift_r,      shift_nxt_s;
  logic          byte_vld_r,   byte_vld_nxt_s;
  logic          frm_err_r,    frm_err_nxt_s;
  logic          baud_done_s;
  logic          fall_s;

  asm_state_t    asm_state_r,  asm_state_nxt_s;
  logic [TW-1:0] to_cnt_r,     to_cnt_nxt_s;
  logic [TW-1:0] to_cnt_inc_s;
  logic [15:0]   cmd_r,        cmd_nxt_s;
  logic          cmd_rdy_r,    cmd_rdy_nxt_s;
  logic          ovr_err_r,    ovr_err_nxt_s;
  logic          to_err_r,     to_err_nxt_s;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rxs_r     <= rx_meta_r;
      rx_prev_r <= rxs_r;
    end
  end

  assign fall_s      = rx_prev_r & ~rxs_r;
  assign baud_done_s = (baud_cnt_r == {BW{1'b0}});

  // Bit FSM next state: samples mid-bit, start bit re-checked to reject glitches.
  always_comb begin
    bit_state_nxt_s = bit_state_r;
    baud_cnt_nxt_s  = baud_cnt_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    shift_nxt_s     = shift_r;
    byte_vld_nxt_s  = 1'b0;
    frm_err_nxt_s   = 1'b0;
    case (bit_state_r)
      B_IDLE: begin
        if (fall_s) begin
          bit_state_nxt_s = B_START;
          baud_cnt_nxt_s  = HALF_LOAD;
        end else begin
          baud_cnt_nxt_s  = {BW{1'b0}};
        end
      end
      B_START: begin
        if (!baud_done_s) begin
          baud_cnt_nxt_s = baud_cnt_r - BW'(1'b1);
        end else if (!rxs_r) begin
          bit_state_nxt_s = B_DATA;
          baud_cnt_nxt_s  = FULL_LOAD;
          bit_cnt_nxt_s   = 3'd0;
        end else begin
          bit_state_nxt_s = B_IDLE;
        end
      end
      B_DATA: begin
        if (!baud_done_s) begin
          baud_cnt_nxt_s = baud_cnt_r - BW'(1'b1);
        end else begin
          shift_nxt_s    = {rxs_r, shift_r[7:1]};
          baud_cnt_nxt_s = FULL_LOAD;
          if (bit_cnt_r == 3'd7) begin
            bit_state_nxt_s = B_STOP;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end
        end
      end
      B_STOP: begin
        if (!baud_done_s) begin
          baud_cnt_nxt_s = baud_cnt_r - BW'(1'b1);
        end else begin
          bit_state_nxt_s = B_IDLE;
          if (rxs_r) begin
            byte_vld_nxt_s = 1'b1;
          end else begin
            frm_err_nxt_s  = 1'b1;
          end
        end
      end
      default: begin
        bit_state_nxt_s = B_IDLE;
        baud_cnt_nxt_s  = {BW{1'b0}};
      end
    endcase
  end

  // Bit FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_state_r <= B_IDLE;
      baud_cnt_r  <= {BW{1'b0}};
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      byte_vld_r  <= 1'b0;
      frm_err_r   <= 1'b0;
    end else begin
      bit_state_r <= bit_state_nxt_s;
      baud_cnt_r  <= baud_cnt_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      shift_r     <= shift_nxt_s;
      byte_vld_r  <= byte_vld_nxt_s;
      frm_err_r   <= frm_err_nxt_s;
    end
  end

  assign to_cnt_inc_s = to_cnt_r + TW'(1'b1);

  // Assembler next state: a byte on the timeout cycle still completes the command.
  always_comb begin
    asm_state_nxt_s = asm_state_r;
    to_cnt_nxt_s    = to_cnt_r;
    cmd_nxt_s       = cmd_r;
    cmd_rdy_nxt_s   = cmd_rdy_r;
    ovr_err_nxt_s   = 1'b0;
    to_err_nxt_s    = 1'b0;
    case (asm_state_r)
      A_WAIT_HI: begin
        if (byte_vld_r) begin
          cmd_nxt_s[15:8] = shift_r;
          to_cnt_nxt_s    = {TW{1'b0}};
          asm_state_nxt_s = A_WAIT_LO;
        end else begin
          to_cnt_nxt_s    = to_cnt_r;
        end
      end
      A_WAIT_LO: begin
        if (byte_vld_r) begin
          cmd_nxt_s[7:0]  = shift_r;
          cmd_rdy_nxt_s   = 1'b1;
          asm_state_nxt_s = A_HOLD;
        end else if (frm_err_r) begin
          asm_state_nxt_s = A_WAIT_HI;
        end else if (to_cnt_inc_s == TO_LIMIT) begin
          to_err_nxt_s    = 1'b1;
          to_cnt_nxt_s    = to_cnt_inc_s;
          asm_state_nxt_s = A_WAIT_HI;
        end else begin
          to_cnt_nxt_s    = to_cnt_inc_s;
        end
      end
      A_HOLD: begin
        ovr_err_nxt_s = byte_vld_r;
        if (cmd_if.clr_cmd_rdy) begin
          cmd_rdy_nxt_s   = 1'b0;
          asm_state_nxt_s = A_WAIT_HI;
        end else begin
          cmd_rdy_nxt_s   = 1'b1;
        end
      end
      default: begin
        asm_state_nxt_s = A_WAIT_HI;
        cmd_rdy_nxt_s   = 1'b0;
      end
    endcase
  end

  // Assembler state, command and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_state_r <= A_WAIT_HI;
      to_cnt_r    <= {TW{1'b0}};
      cmd_r       <= 16'h0000;
      cmd_rdy_r   <= 1'b0;
      ovr_err_r   <= 1'b0;
      to_err_r    <= 1'b0;
    end else begin
      asm_state_r <= asm_state_nxt_s;
      to_cnt_r    <= to_cnt_nxt_s;
      cmd_r       <= cmd_nxt_s;
      cmd_rdy_r   <= cmd_rdy_nxt_s;
      ovr_err_r   <= ovr_err_nxt_s;
      to_err_r    <= to_err_nxt_s;
    end
  end

  assign cmd_if.cmd     = cmd_r;
  assign cmd_if.cmd_rdy = cmd_rdy_r;
  assign cmd_if.frm_err = frm_err_r;
  assign cmd_if.ovr_err = ovr_err_r;
  assign cmd_if.to_err  = to_err_r;

endmodule
